serial_add_ctrl: RTL

- Bit-serial adder controller that wraps the single-bit add cell from the combinational library.
- Accepts two WIDTH-bit operands on a start strobe.
- Presents one LSB-first bit pair per clock to a half-add-plus-carry datapath and holds a registered carry between cycles.
- Assembles the WIDTH-bit sum and the final carry-out, then pulses done.
- Sits between a simple operand source (testbench or register file) and any consumer of the finished sum.

---
 rtl/serial_add_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial unsigned adder controller.  On an accepted start strobe it
//   captures two WIDTH-bit operands. It then feeds one LSB-first bit pair per
//   clock through a single-bit add cell, keeping the carry in a flop between
//   cycles. After WIDTH bit-steps it publishes the assembled sum and the final
//   carry-out together, and pulses done for one cycle.
//
//   Latency : start accepted at edge E0 -> result/cout/done update at E0+WIDTH.
//   Flow    : busy is high for WIDTH cycles. A start during that time is
//             ignored. A start in the done cycle is accepted, so the minimum
//             issue interval is WIDTH+1.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset; wins over start and over an
//             in-flight add (an aborted add never pulses done)
//   start   : add request, sampled only while idle
//   a_in    : operand A, captured on the accepting edge
//   b_in    : operand B, captured on the accepting edge
//   busy    : serial add in progress
//   done    : one-cycle completion pulse
//   result  : WIDTH-bit sum, held between completions
//   cout    : carry-out of the MSB, held with result
// -----------------------------------------------------------------------------

// Single-bit full-add cell: sum and carry of two operand bits plus carry-in.
module serial_add_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic half_sum;

  // Half-add of the operand bits, then fold in the carry.
  assign half_sum = a_i ^ b_i;
  assign s_o      = half_sum ^ c_i;
  assign c_o      = (a_i & b_i) | (c_i & half_sum);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [WIDTH-1:0] a_q;        // operand A, shifted right one bit per step
  logic [WIDTH-1:0] b_q;        // operand B, shifted right one bit per step
  logic [WIDTH-1:0] sum_q;      // partial sum, new bits enter at the MSB
  logic             carry_q;    // carry between successive bit-steps
  logic [CNT_W-1:0] cnt_q;      // index of the bit being added this cycle
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;

  // ---------------------------------------------------------------------------
  // Datapath: one bit-step per cycle
  // ---------------------------------------------------------------------------
  logic             bit_s;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [CNT_W-1:0] cnt_d;
  logic             last_step;

  serial_add_bit_cell u_bit_cell (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (bit_s),
    .c_o (carry_d)
  );

  always_comb begin
    // Sum bits arrive LSB first. Shifting them in at the top leaves
    // the complete word correctly aligned after exactly WIDTH steps.
    sum_d     = {bit_s, sum_q[WIDTH-1:1]};
    a_d       = a_q >> 1;
    b_d       = b_q >> 1;
    cnt_d     = cnt_q + CNT_ONE;
    last_step = (cnt_q == LAST_CNT);
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      // done is a single-cycle pulse. It is re-raised only on a completion edge.
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // start, a_in and b_in are intentionally ignored here.
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_d;
          if (last_step) begin
            // Publish the whole word at once so result never shows a
            // partially assembled sum.
            result_q <= sum_d;
            cout_q   <= carry_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule
